// File: rtl/msg_tx_pkg.sv
// Shared types and defaults for the message streamer and its ROM image.
package msg_tx_pkg;

   localparam int unsigned DEFAULT_MSG_LEN    = 13;
   localparam int unsigned DEFAULT_ADDR_W     = 4;
   localparam int unsigned DEFAULT_DATA_W     = 8;
   localparam int unsigned DEFAULT_GAP_CYCLES = 0;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WRITE,
      SETTLE,
      WAIT_EMPTY,
      GAP
   } state_t;

   // A zero-cycle gap still needs a legal (1-bit) counter
   function automatic int unsigned gap_cnt_w(input int unsigned cycles);
      return (cycles > 0) ? $clog2(cycles + 1) : 1;
   endfunction

endpackage

// File: rtl/msg_tx_gap_timer.sv
// Load/count-down timer; expired is high during the final counted clock.
module msg_tx_gap_timer
   import msg_tx_pkg::*;
#(
   parameter int unsigned CYCLES = 1
)(
   input  logic clk,
   input  logic resn,
   input  logic load,
   input  logic dec,
   output logic expired
);

   localparam int unsigned W = gap_cnt_w(CYCLES);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge resn) begin
      if (!resn) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= W'(CYCLES);
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign expired = (cnt == W'(1));

endmodule

// File: rtl/msg_tx_streamer.sv
// Streams an MSG_LEN-character ROM message into uartTx via its wr/empty handshake.
// Continuous mode and the inter-message gap exist only when MSG_TX_REPEAT_EN is defined.
module msg_tx_streamer
   import msg_tx_pkg::*;
#(
   parameter int unsigned MSG_LEN    = DEFAULT_MSG_LEN,
   parameter int unsigned ADDR_W     = DEFAULT_ADDR_W,
   parameter int unsigned DATA_W     = DEFAULT_DATA_W,
   parameter int unsigned GAP_CYCLES = DEFAULT_GAP_CYCLES
)(
   input  logic              clk,
   input  logic              resn,
   input  logic              start,
   input  logic              repeat_en,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic              tx_wr,
   output logic [DATA_W-1:0] tx_data,
   input  logic              tx_empty,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MSG_LEN - 1);

   state_t state, state_nxt;
   logic   last;
   logic   msg_end;

`ifdef MSG_TX_REPEAT_EN
   logic gap_load;
   logic gap_expired;

   msg_tx_gap_timer #(
      .CYCLES (GAP_CYCLES)
   ) u_gap_timer (
      .clk     (clk),
      .resn    (resn),
      .load    (gap_load),
      .dec     (state == GAP),
      .expired (gap_expired)
   );
`else
   logic unused_cfg;
   assign unused_cfg = repeat_en ^ (GAP_CYCLES != 0);
`endif

   always_comb begin
      state_nxt = state;
      msg_end   = 1'b0;
`ifdef MSG_TX_REPEAT_EN
      gap_load  = 1'b0;
`endif
      case (state)
         IDLE:       if (start) state_nxt = FETCH;
         FETCH:      state_nxt = WRITE;
         WRITE:      state_nxt = SETTLE;
         SETTLE:     state_nxt = WAIT_EMPTY;
         WAIT_EMPTY: begin
            if (tx_empty) begin
               if (!last) begin
                  state_nxt = FETCH;
               end else begin
                  msg_end = 1'b1;
`ifdef MSG_TX_REPEAT_EN
                  if (repeat_en && (GAP_CYCLES > 0)) begin
                     state_nxt = GAP;
                     gap_load  = 1'b1;
                  end else if (repeat_en) begin
                     state_nxt = FETCH;
                  end else begin
                     state_nxt = IDLE;
                  end
`else
                  state_nxt = IDLE;
`endif
               end
            end
         end
`ifdef MSG_TX_REPEAT_EN
         GAP:        if (gap_expired) state_nxt = FETCH;
`endif
         default:    state_nxt = IDLE;
      endcase
   end

   // rom_addr is the character index; it only moves at the end of WRITE
   always_ff @(posedge clk or negedge resn) begin
      if (!resn) begin
         state    <= IDLE;
         rom_addr <= '0;
         tx_data  <= '0;
         last     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= msg_end;
         if (state == FETCH) tx_data <= rom_data;
         if (state == WRITE) begin
            if (rom_addr == LAST_IDX) begin
               rom_addr <= '0;
               last     <= 1'b1;
            end else begin
               rom_addr <= rom_addr + 1'b1;
            end
         end
         if (msg_end) last <= 1'b0;
      end
   end

   assign tx_wr = (state == WRITE);
   assign busy  = (state != IDLE);

endmodule

// File: tb/tb_msg_tx_streamer.sv
// Self-checking bench for msg_tx_streamer: randomized uartTx busy time and ROM contents,
// checked against a message-position model of the expected character stream.
module tb_msg_tx_streamer;
   import msg_tx_pkg::*;

   localparam int unsigned N   = DEFAULT_MSG_LEN;
   localparam int unsigned GAP = 100;
`ifdef MSG_TX_REPEAT_EN
   localparam bit REPEAT_BUILD = 1'b1;
`else
   localparam bit REPEAT_BUILD = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       resn = 1'b0;
   logic       start = 1'b0;
   logic       repeat_en = 1'b0;
   logic [3:0] rom_addr;
   logic [7:0] rom_data;
   logic       tx_wr;
   logic [7:0] tx_data;
   logic       tx_empty = 1'b1;
   logic       busy;
   logic       done;

   logic       start1 = 1'b0;
   logic       repeat_en1 = 1'b0;
   logic       tx_empty1 = 1'b1;
   logic [0:0] rom_addr1;
   logic [7:0] rom_data1;
   logic       tx_wr1;
   logic [7:0] tx_data1;
   logic       busy1;
   logic       done1;

   logic [7:0] rom [16];
   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   msg_tx_streamer #(
      .MSG_LEN    (N),
      .ADDR_W     (4),
      .DATA_W     (8),
      .GAP_CYCLES (GAP)
   ) dut (
      .clk       (clk),
      .resn      (resn),
      .start     (start),
      .repeat_en (repeat_en),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .tx_wr     (tx_wr),
      .tx_data   (tx_data),
      .tx_empty  (tx_empty),
      .busy      (busy),
      .done      (done)
   );

   msg_tx_streamer #(
      .MSG_LEN    (1),
      .ADDR_W     (1),
      .DATA_W     (8),
      .GAP_CYCLES (0)
   ) dut1 (
      .clk       (clk),
      .resn      (resn),
      .start     (start1),
      .repeat_en (repeat_en1),
      .rom_addr  (rom_addr1),
      .rom_data  (rom_data1),
      .tx_wr     (tx_wr1),
      .tx_data   (tx_data1),
      .tx_empty  (tx_empty1),
      .busy      (busy1),
      .done      (done1)
   );

   // Synchronous ROMs with one clock of read latency
   always @(posedge clk) rom_data  <= rom[rom_addr];
   always @(posedge clk) rom_data1 <= rom_addr1[0] ? 8'hEE : 8'h41;

   // uartTx stand-in: holding register busy for a random number of clocks after each write
   int hold = 0;
   int min_hold = 1;
   always @(posedge clk) begin
      if (tx_wr) begin
         tx_empty <= 1'b0;
         hold     <= int'($urandom_range(12, min_hold));
      end else if (hold > 1) begin
         hold <= hold - 1;
      end else begin
         tx_empty <= 1'b1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: the stream is msg[0..N-1] repeated; pos is the next expected index
   int cyc = 0;
   logic rep_q = 1'b0;
   int wr_count = 0;
   int done_count = 0;
   int pos = 0;
   int done_cyc = 0;
   bit gap_pending = 1'b0;
   always @(posedge clk) cyc   <= cyc + 1;
   always @(posedge clk) rep_q <= repeat_en;

   always @(negedge clk) begin
      if (resn) begin
         if (tx_wr) begin
            check("tx_data", tx_data, rom[pos]);
            if (gap_pending) begin
               check("repeat_gap", cyc - done_cyc, GAP + 1);
               gap_pending = 1'b0;
            end
            wr_count++;
            pos = (pos + 1) % N;
         end
         if (done) begin
            done_count++;
            check("done_pos", pos, 0);
            check("done_busy", busy, rep_q && REPEAT_BUILD);
            gap_pending = rep_q && REPEAT_BUILD;
            done_cyc    = cyc;
         end
      end
   end

   int wr1 = 0;
   int done1_cnt = 0;
   logic [7:0] last1 = 8'h00;
   always @(negedge clk) begin
      if (resn) begin
         if (tx_wr1) begin
            wr1++;
            last1 = tx_data1;
         end
         if (done1) done1_cnt++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic pulse_start();
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_wr(input int target);
      int k = 0;
      while (wr_count < target && k < 20000) begin
         @(negedge clk);
         k++;
      end
      check("wait_wr_timeout", wr_count >= target, 1);
   endtask

   task automatic wait_done(input int target);
      int k = 0;
      while (done_count < target && k < 20000) begin
         @(negedge clk);
         k++;
      end
      check("wait_done_timeout", done_count >= target, 1);
   endtask

   task automatic load_hello();
      logic [103:0] hello_bits;
      hello_bits = "Hello World!\n";
      for (int i = 0; i < 16; i++) rom[i] = 8'h00;
      for (int i = 0; i < 13; i++) rom[i] = hello_bits[8*(12-i) +: 8];
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: observed no finish expected finish");
      $fatal(1, "global timeout");
   end

   initial begin
      int w0;
      int d0;
      load_hello();

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_rom_addr", rom_addr, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_tx_wr", tx_wr, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      tick();
      resn = 1'b1;

      // Single shot of "Hello World!\n": 2-clock start latency, stray start ignored
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      @(negedge clk);
      check("lat_fetch_busy", busy, 1);
      check("lat_fetch_wr", tx_wr, 0);
      @(negedge clk);
      check("lat_write_wr", tx_wr, 1);
      check("lat_first_char", tx_data, 8'h48);
      wait_wr(5);
      pulse_start();
      wait_done(1);
      repeat (30) @(negedge clk);
      check("single_wr_total", wr_count, N);
      check("single_done_total", done_count, 1);
      check("single_idle_busy", busy, 0);
      check("single_idle_addr", rom_addr, 0);

      // Random message contents
      for (int i = 0; i < 13; i++) rom[i] = 8'($urandom);
      w0 = wr_count;
      d0 = done_count;
      pulse_start();
      wait_done(d0 + 1);
      repeat (30) @(negedge clk);
      check("rand_wr_total", wr_count - w0, N);
      check("rand_busy", busy, 0);
      load_hello();

      // Continuous mode, dropped part-way into the third message
      w0 = wr_count;
      d0 = done_count;
      tick();
      repeat_en = 1'b1;
      pulse_start();
`ifdef MSG_TX_REPEAT_EN
      wait_wr(w0 + 2*N + 3);
      tick();
      repeat_en = 1'b0;
      wait_done(d0 + 3);
      repeat (300) @(negedge clk);
      check("rep_done_total", done_count - d0, 3);
      check("rep_wr_total", wr_count - w0, 3*N);
`else
      wait_done(d0 + 1);
      repeat (300) @(negedge clk);
      check("rep_done_total", done_count - d0, 1);
      check("rep_wr_total", wr_count - w0, N);
      tick();
      repeat_en = 1'b0;
`endif
      check("rep_busy", busy, 0);

      // Asynchronous reset in WAIT_EMPTY of character 7
      min_hold = 10;
      w0 = wr_count;
      pulse_start();
      wait_wr(w0 + 7);
      repeat (3) @(negedge clk);
      #1;
      resn = 1'b0;
      pos = 0;
      gap_pending = 1'b0;
      #1;
      check("arst_tx_wr", tx_wr, 0);
      check("arst_busy", busy, 0);
      check("arst_rom_addr", rom_addr, 0);
      check("arst_done", done, 0);
      tick();
      tick();
      resn = 1'b1;
      min_hold = 1;
      repeat (5) @(negedge clk);
      check("arst_stays_idle", busy, 0);
      d0 = done_count;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (2) @(negedge clk);
      check("arst_restart_wr", tx_wr, 1);
      check("arst_restart_char", tx_data, 8'h48);
      wait_done(d0 + 1);
      repeat (30) @(negedge clk);
      check("arst_final_busy", busy, 0);

      // MSG_LEN = 1
      tick();
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      repeat (20) @(negedge clk);
      check("len1_wr_total", wr1, 1);
      check("len1_char", last1, 8'h41);
      check("len1_done_total", done1_cnt, 1);
      check("len1_busy", busy1, 0);
      check("len1_addr", rom_addr1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/msg_tx_streamer.md
# msg_tx_streamer

Parametrised message streamer. On a start request it reads an N-character message from an external synchronous ROM and feeds it byte by byte into the `uartTx` transmitter, observing its `wr`/`empty` handshake. It supports single-shot or continuously repeating transmission with a programmable inter-message gap. It sits between the message ROM and `uartTx` and is the generalised successor of the fixed "Hello World!" sender.

## Interface
Parameters:
- `MSG_LEN`, default 13: number of characters per message; must be ≥1.
- `ADDR_W`, default 4: ROM address width; must satisfy `MSG_LEN` ≤ 2^`ADDR_W`.
- `DATA_W`, default 8: character width.
- `GAP_CYCLES`, default 0: idle clocks between repeated messages.

Ports:
- `clk`, in, 1: single clock. Everything is synchronous to its rising edge.
- `resn`, in, 1: reset. Asynchronous, active-low.
- `start`, in, 1: start request. Sampled only in IDLE.
- `repeat_en`, in, 1: continuous mode. Sampled when the last character is accepted.
- `rom_addr`, out, `ADDR_W`: character index driven to the ROM.
- `rom_data`, in, `DATA_W`: ROM output, valid one clock after `rom_addr`.
- `tx_wr`, out, 1: one-clock write strobe to `uartTx`.
- `tx_data`, out, `DATA_W`: registered character to `uartTx`.
- `tx_empty`, in, 1: `uartTx` holding register ready.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-clock pulse when a message's last character has been accepted.

## Operation
- States:
  - IDLE: `start`=1 → FETCH.
  - FETCH (1 clk): capture `rom_data` into `tx_data` → WRITE.
  - WRITE (1 clk): `tx_wr`=1. The index advances to index+1, or to 0 if index = `MSG_LEN`-1, which also sets the internal `last` flag → SETTLE.
  - SETTLE (1 clk): ignores `tx_empty`, allowing for the transmitter's empty-drop latency → WAIT_EMPTY.
  - WAIT_EMPTY: hold until `tx_empty`=1. When it arrives:
    - `last`=0 → FETCH.
    - `last`=1 → pulse `done` and clear `last`. Then:
      - `repeat_en`=1 and `GAP_CYCLES`>0 → GAP.
      - `repeat_en`=1 and `GAP_CYCLES`=0 → FETCH.
      - otherwise → IDLE.
  - GAP: count `GAP_CYCLES` clocks → FETCH.
- `rom_addr` is the index register itself. It changes only at the end of WRITE, so it is stable for at least 2 clocks before the next FETCH. This satisfies the 1-clock ROM latency.
- `done` means the last character was accepted into the holding register, not that it has been shifted out.
- `start` while busy is ignored and not queued.
- Deasserting `repeat_en` mid-message lets the current message complete, then the block returns to IDLE.
- `MSG_LEN`=1: every message is a single WRITE with `last` set.

## Timing
- Reset values:
  - state = IDLE.
  - `rom_addr`=0, `tx_data`=0.
  - `tx_wr`=0, `busy`=0, `done`=0, `last`=0, gap count=0.
- Reset mid-operation takes effect immediately (asynchronous) and drops `tx_wr` at once. After release the block stays in IDLE until the next `start`.
- Latency from `start` sampled high to first `tx_wr` is 2 clocks (IDLE→FETCH→WRITE).
- Per-character minimum is 4 clocks (FETCH, WRITE, SETTLE, WAIT_EMPTY with `tx_empty` already high). `uartTx` normally dominates this.
- `done` is asserted in the clock after the final WAIT_EMPTY exit. It is concurrent with the first clock of GAP, FETCH or IDLE.
- Repeat period = message time + `GAP_CYCLES` clocks, measured from last-character acceptance to the next FETCH.
- Widths:
  - Gap counter width is $clog2(`GAP_CYCLES`+1).
  - Index compare is against `MSG_LEN`-1 at `ADDR_W` bits.
  - No arithmetic overflow is possible.

## Configuration
- `MSG_TX_REPEAT_EN`:
  - Defined: continuous mode and the GAP state are compiled in, as described above.
  - Undefined: `repeat_en` is ignored, GAP and the gap counter are absent, and after the last character the block always returns to IDLE. Single-shot only.

## Structure
- `msg_tx_pkg`: state enum (IDLE, FETCH, WRITE, SETTLE, WAIT_EMPTY, GAP), default parameter constants, and a `DEFAULT_MSG_LEN`=13 constant shared with the ROM init.
- One sub-module, `msg_tx_gap_timer`: a load/count-down timer with a `expired` output. It is instantiated only under `MSG_TX_REPEAT_EN`.

## Test plan
- Single-shot, ROM = "Hello World!\n", `uartTx` model with `tx_empty` low for 10 clocks after each `wr` → exactly 13 `tx_wr` pulses carrying 0x48…0x0A in order, then one `done` pulse, `busy` low, `rom_addr`=0.
- `repeat_en`=1, `GAP_CYCLES`=100 → two complete messages, with exactly 100 clocks between the second `done` pulse and the next FETCH. Drop `repeat_en` in the third message → 3 `done` pulses total, then IDLE.
- `start` pulsed again during character 5 → ignored; total `tx_wr` count remains 13.
- `MSG_LEN`=1, ROM[0]=0x41 → one `tx_wr` with `tx_data`=0x41, `done` pulse, return to IDLE.
- `resn` asserted in WAIT_EMPTY of character 7 → `tx_wr`, `busy` and `rom_addr` read 0 in the same clock. The next `start` restarts from character 0 (0x48).
- `MSG_TX_REPEAT_EN` undefined, `repeat_en`=1 → a single message only, then IDLE.
